response_scoreboard: RTL
========================

# response_scoreboard

Synthesizable end-of-chain checker for the single-output comparison benches. It consumes the reference-model and DUT outputs sampled on each accepted cycle, counts samples and mismatches, and captures the index and bit pattern of the first mismatch. It drives a pass/fail verdict once a programmed number of samples has been checked. It pairs with the stimulus generator as the response-side end of the bench, so the bench verdict can be checked in RTL/FPGA as well as in simulation.

## Interface
- WIDTH, 1, number of compared output bits
- NUM_SAMPLES, 101, samples per run before verdict (≥1)
- CNT_W, 16, width of sample/error counters (2^CNT_W−1 ≥ NUM_SAMPLES)

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  begin a run (accepted in IDLE or DONE only)
- sample_en  in  1  current ref/dut pair is a valid sample
- ref_out  in  WIDTH  reference-model output
- dut_out  in  WIDTH  DUT output
- busy  out  1  high in RUN
- done  out  1  high in DONE
- pass  out  1  valid when done; 1 iff error_count == 0
- sample_count  out  CNT_W  samples accepted this run
- error_count  out  CNT_W  mismatching samples this run, saturating
- first_err_valid  out  1  a mismatch has been captured this run
- first_err_idx  out  CNT_W  sample index (0-based) of first mismatch
- first_err_diff  out  WIDTH  ref_out ^ dut_out at first mismatch

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: start=1 → RUN; all counters/captures already zero.
- RUN: each cycle with sample_en=1 is one sample, idx = current sample_count.
  - sample_count += 1.
  - mismatch = |(ref_out ^ dut_out). If mismatch: error_count += 1 unless at 2^CNT_W−1 (holds); if first_err_valid=0, capture first_err_idx=idx, first_err_diff=ref_out^dut_out, set first_err_valid.
  - Sample that makes sample_count reach NUM_SAMPLES → DONE; its mismatch is counted.
  - sample_en=0: no counter changes. start ignored in RUN.
- DONE: outputs frozen; sample_en ignored. start=1 → clear sample_count, error_count, first_err_* to 0 and enter RUN (same cycle transition; first sample may arrive the next cycle).
- pass = done & (error_count == 0); 0 outside DONE.
- Per-bit mismatch is counted once per sample regardless of how many bits differ.
- Comparison is 2-state; X/Z handling is the bench's responsibility.

## Timing
- Reset values: busy=0, done=0, pass=0, sample_count=0, error_count=0, first_err_valid=0, first_err_idx=0, first_err_diff=0.
- All outputs registered; sample at edge N reflected on outputs after edge N (1-cycle latency).
- done and pass assert in the cycle after the edge that accepts sample NUM_SAMPLES−1; busy deasserts the same cycle.
- start accepted at edge N → busy=1 after edge N; counters read 0 until the first sample edge.
- reset has priority over start and sample_en; reset mid-RUN aborts to IDLE with all outputs at reset values after the edge.
- Simultaneous start and sample_en in IDLE/DONE: start taken, sample dropped.
- Saturation: error_count never wraps; sample_count cannot exceed NUM_SAMPLES.

## Test plan
- WIDTH=1, NUM_SAMPLES=8: reset, start, 8 samples with ref==dut → after 8th sample edge: done=1, pass=1, sample_count=8, error_count=0, first_err_valid=0.
- Same, ref_out=1/dut_out=0 on samples 3 and 6 → error_count=2, first_err_idx=3, first_err_diff=1, pass=0.
- WIDTH=2, mismatch on sample 0 with ref=2'b10, dut=2'b01 → error_count=1, first_err_diff=2'b11, first_err_idx=0; also verify mismatch on the final sample (idx 7) is counted.
- sample_en toggled 1/0 every cycle, start asserted mid-RUN → only enabled cycles counted, start ignored; done after 8 enabled cycles (16 cycles).
- Reset asserted after 4 samples with 1 error → all outputs zero next cycle, state IDLE; new start yields fresh run with no carry-over.
- CNT_W=3, NUM_SAMPLES=7, all mismatching → error_count saturates at 7; start in DONE clears counts and restarts; concurrent sample_en on that edge is dropped.

Source files
------------

// File: rtl/response_scoreboard.sv
// response_scoreboard: end-of-chain checker that compares reference and DUT
// outputs per accepted sample, counts samples and mismatches, captures the
// first mismatch and raises a pass/fail verdict after a fixed sample count.
module response_scoreboard #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned NUM_SAMPLES = 101,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] ref_out,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] error_count,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_diff
);

  // Index of the sample that completes a run.
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [CNT_W-1:0] ErrMax  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             fe_valid_q, fe_valid_d;
  logic [CNT_W-1:0] fe_idx_q, fe_idx_d;
  logic [WIDTH-1:0] fe_diff_q, fe_diff_d;

  logic [WIDTH-1:0] diff;
  logic             mismatch;

  assign diff     = ref_out ^ dut_out;
  assign mismatch = |diff;

  // Next-state logic: run control plus sample/error accounting.
  always_comb begin
    state_d    = state_q;
    smp_cnt_d  = smp_cnt_q;
    err_cnt_d  = err_cnt_q;
    fe_valid_d = fe_valid_q;
    fe_idx_d   = fe_idx_q;
    fe_diff_d  = fe_diff_q;
    unique case (state_q)
      StIdle, StDone: begin
        // A new run always starts from cleared counters; any sample on this
        // edge is dropped.
        if (start) begin
          state_d    = StRun;
          smp_cnt_d  = '0;
          err_cnt_d  = '0;
          fe_valid_d = 1'b0;
          fe_idx_d   = '0;
          fe_diff_d  = '0;
        end
      end
      StRun: begin
        if (sample_en) begin
          smp_cnt_d = smp_cnt_q + 1'b1;
          if (mismatch) begin
            if (err_cnt_q != ErrMax) err_cnt_d = err_cnt_q + 1'b1;
            if (!fe_valid_q) begin
              fe_valid_d = 1'b1;
              fe_idx_d   = smp_cnt_q;
              fe_diff_d  = diff;
            end
          end
          if (smp_cnt_q == LastIdx) state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      smp_cnt_q  <= '0;
      err_cnt_q  <= '0;
      fe_valid_q <= 1'b0;
      fe_idx_q   <= '0;
      fe_diff_q  <= '0;
    end else begin
      state_q    <= state_d;
      smp_cnt_q  <= smp_cnt_d;
      err_cnt_q  <= err_cnt_d;
      fe_valid_q <= fe_valid_d;
      fe_idx_q   <= fe_idx_d;
      fe_diff_q  <= fe_diff_d;
    end
  end

  assign busy            = (state_q == StRun);
  assign done            = (state_q == StDone);
  assign pass            = (state_q == StDone) && (err_cnt_q == '0);
  assign sample_count    = smp_cnt_q;
  assign error_count     = err_cnt_q;
  assign first_err_valid = fe_valid_q;
  assign first_err_idx   = fe_idx_q;
  assign first_err_diff  = fe_diff_q;

endmodule
